tpu_tile_sequencer: RTL and testbench

Parametrised next-generation TPU system controller. Sequences weight/compensation-weight preload, activation broadcast, accumulator write, and unified-buffer writeback for a SIZE x SIZE systolic array. Unlike the single-pattern controller, it runs NUM tiles back to back with cross-tile accumulation, a start/busy/done handshake, and abort. Sits between the host write interface and the weight/activation/compensation memories, array, and accumulators.

---
 rtl/tpu_tile_sequencer.sv | 172 +++++++++++++++++
 tb/tb_tpu_tile_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_tile_sequencer.sv
// rtl/tpu_tile_sequencer.sv - multi-tile preload/compute/writeback sequencer for a SIZE x SIZE systolic array
// State advances on the falling clock edge; most outputs decode directly from state, k and tile index.
module tpu_tile_sequencer #(
   parameter int SIZE      = 8,
   parameter int CW_ROWS   = 3,
   parameter int MAX_TILES = 16,
   parameter int WADDR_W   = $clog2(SIZE*MAX_TILES),
   parameter int CADDR_W   = $clog2(CW_ROWS*MAX_TILES),
   parameter int TILE_W    = $clog2(MAX_TILES+1)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       mem_write,
   input  logic                       comp_out_valid,
   input  logic                       start,
   input  logic                       abort,
   input  logic [TILE_W-1:0]          num_tiles,
   output logic                       busy,
   output logic                       done,
   output logic                       weight_mem_wr_en,
   output logic                       act_mem_wr_en,
   output logic                       comp_mem_wr_en,
   output logic                       weight_rd_en,
   output logic                       act_rd_en,
   output logic                       comp_rd_en,
   output logic [WADDR_W-1:0]         weight_rd_addr,
   output logic [WADDR_W-1:0]         act_rd_addr,
   output logic [CADDR_W-1:0]         comp_rd_addr,
   output logic                       weight_out_valid,
   output logic                       cweight_out_valid,
   output logic                       cal,
   output logic                       acc_first,
   output logic                       cacc_wr_en,
   output logic [SIZE-1:0]            acc_wr_en,
   output logic                       acc_rd_en,
   output logic                       ub_wr_en,
   output logic [$clog2(SIZE)-1:0]    ub_wr_addr
);

   localparam int K_W  = $clog2(3*SIZE+2);
   localparam int UB_W = $clog2(SIZE);

   typedef enum logic [2:0] {S_IDLE, S_PRELOAD, S_CAL, S_OUT, S_DONE} state_t;

   state_t            state;
   logic [K_W-1:0]    k;
   logic [TILE_W-1:0] t;
   logic [TILE_W-1:0] num_lat;
   logic [TILE_W-1:0] num_clamped;
   logic              last_k;
   logic [31:0]       k32;
   logic [31:0]       t32;

   assign k32 = 32'(k);
   assign t32 = 32'(t);

   always_comb begin
      num_clamped = num_tiles;
      if (num_tiles == '0)
         num_clamped = TILE_W'(1);
      else if (num_tiles > TILE_W'(MAX_TILES))
         num_clamped = TILE_W'(MAX_TILES);
   end

   always_comb begin
      case (state)
         S_PRELOAD: last_k = (k == K_W'(SIZE-1));
         S_CAL:     last_k = (k == K_W'(3*SIZE));
         S_OUT:     last_k = (k == K_W'(SIZE));
         default:   last_k = 1'b1;
      endcase
   end

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         state             <= S_IDLE;
         k                 <= '0;
         t                 <= '0;
         num_lat           <= '0;
         weight_out_valid  <= 1'b0;
         cweight_out_valid <= 1'b0;
      end else if (abort && state != S_IDLE) begin
         state             <= S_IDLE;
         k                 <= '0;
         t                 <= '0;
         weight_out_valid  <= 1'b0;
         cweight_out_valid <= 1'b0;
      end else begin
         // Memory reads return one cycle later, so valids trail the read enables.
         weight_out_valid  <= weight_rd_en;
         cweight_out_valid <= comp_rd_en;
         k                 <= last_k ? '0 : k + K_W'(1);
         case (state)
            S_IDLE: begin
               if (start && !mem_write) begin
                  state   <= S_PRELOAD;
                  t       <= '0;
                  num_lat <= num_clamped;
               end
            end
            S_PRELOAD: if (last_k) state <= S_CAL;
            S_CAL: begin
               if (last_k) begin
                  if (t != num_lat - TILE_W'(1)) begin
                     t     <= t + TILE_W'(1);
                     state <= S_PRELOAD;
                  end else begin
                     state <= S_OUT;
                  end
               end
            end
            S_OUT: if (last_k) state <= S_DONE;
            default: begin
               state <= S_IDLE;
               t     <= '0;
            end
         endcase
      end
   end

   always_comb begin
      busy             = (state != S_IDLE);
      done             = (state == S_DONE);
      weight_mem_wr_en = (state == S_IDLE) && mem_write;
      act_mem_wr_en    = (state == S_IDLE) && mem_write;
      comp_mem_wr_en   = (state == S_IDLE) && mem_write && comp_out_valid;
      weight_rd_en     = 1'b0;
      act_rd_en        = 1'b0;
      comp_rd_en       = 1'b0;
      weight_rd_addr   = '0;
      act_rd_addr      = '0;
      comp_rd_addr     = '0;
      cal              = 1'b0;
      acc_first        = 1'b0;
      cacc_wr_en       = 1'b0;
      acc_wr_en        = '0;
      acc_rd_en        = 1'b0;
      ub_wr_en         = 1'b0;
      ub_wr_addr       = '0;
      case (state)
         S_PRELOAD: begin
            weight_rd_en   = 1'b1;
            weight_rd_addr = WADDR_W'(t32*SIZE + k32);
            if (k32 < 32'(CW_ROWS)) begin
               comp_rd_en   = 1'b1;
               comp_rd_addr = CADDR_W'(t32*CW_ROWS + k32);
            end
         end
         S_CAL: begin
            cal       = 1'b1;
            acc_first = (t == '0);
            if (k32 < 32'(SIZE)) begin
               act_rd_en   = 1'b1;
               act_rd_addr = WADDR_W'(t32*SIZE + k32);
            end
            cacc_wr_en = (k32 >= 32'(CW_ROWS+2)) && (k32 <= 32'(CW_ROWS+SIZE+1));
            // Column j's results emerge j cycles after column 0 (diagonal skew).
            for (int j = 0; j < SIZE; j++)
               acc_wr_en[j] = (k32 >= 32'(SIZE+2+j)) && (k32 <= 32'(2*SIZE+1+j));
         end
         S_OUT: begin
            acc_rd_en = 1'b1;
            if (k32 >= 32'd1) begin
               ub_wr_en   = 1'b1;
               ub_wr_addr = UB_W'(k32 - 32'd1);
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// tb/tb_tpu_tile_sequencer.sv - self-checking bench for tpu_tile_sequencer
// A timing-formula model predicts every output each cycle; directed jobs pin the model with literals.
module tb_tpu_tile_sequencer;

   localparam int SIZE = 8;
   localparam int CW   = 3;
   localparam int MAXT = 16;
   localparam int P    = 4*SIZE+1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       mem_write = 1'b0, comp_out_valid = 1'b0, start = 1'b0, abort = 1'b0;
   logic [4:0] num_tiles = '0;
   logic       busy, done, weight_mem_wr_en, act_mem_wr_en, comp_mem_wr_en;
   logic       weight_rd_en, act_rd_en, comp_rd_en;
   logic [6:0] weight_rd_addr, act_rd_addr;
   logic [5:0] comp_rd_addr;
   logic       weight_out_valid, cweight_out_valid, cal, acc_first, cacc_wr_en;
   logic [7:0] acc_wr_en;
   logic       acc_rd_en, ub_wr_en;
   logic [2:0] ub_wr_addr;

   tpu_tile_sequencer #(.SIZE(SIZE), .CW_ROWS(CW), .MAX_TILES(MAXT)) dut (
      .clk(clk), .rst(rst), .mem_write(mem_write), .comp_out_valid(comp_out_valid),
      .start(start), .abort(abort), .num_tiles(num_tiles), .busy(busy), .done(done),
      .weight_mem_wr_en(weight_mem_wr_en), .act_mem_wr_en(act_mem_wr_en),
      .comp_mem_wr_en(comp_mem_wr_en), .weight_rd_en(weight_rd_en), .act_rd_en(act_rd_en),
      .comp_rd_en(comp_rd_en), .weight_rd_addr(weight_rd_addr), .act_rd_addr(act_rd_addr),
      .comp_rd_addr(comp_rd_addr), .weight_out_valid(weight_out_valid),
      .cweight_out_valid(cweight_out_valid), .cal(cal), .acc_first(acc_first),
      .cacc_wr_en(cacc_wr_en), .acc_wr_en(acc_wr_en), .acc_rd_en(acc_rd_en),
      .ub_wr_en(ub_wr_en), .ub_wr_addr(ub_wr_addr)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0;
   int cyc = 0, jstart = 0, jn = 1, done_count = 0, last_done_rel = -1;
   bit active = 0, pw = 0, pc = 0;
   int r, tl, o, kk;
   logic e_busy, e_done, e_wmw, e_amw, e_cmw, e_wre, e_are, e_cre, e_wov, e_cwov;
   logic e_cal, e_accf, e_cacc, e_accrd, e_ub;
   logic [6:0] e_wra, e_ara;
   logic [5:0] e_cra;
   logic [7:0] e_acc;
   logic [2:0] e_uba;
   logic [63:0] v_exp, v_act;
   logic [6:0] snap_wra [0:127];
   logic [5:0] snap_cra [0:127];
   logic [7:0] snap_acc [0:127];
   logic [2:0] snap_ub  [0:127];
   logic       snap_accf[0:127];

   function automatic logic [63:0] pack(
      input logic b, d, wmw, amw, cmw, wre, are, cre,
      input logic [6:0] wra, ara, input logic [5:0] cra,
      input logic wov, cwov, cl, accf, cacc, input logic [7:0] acc,
      input logic accrd, ub, input logic [2:0] uba);
      return 64'({b, d, wmw, amw, cmw, wre, are, cre, wra, ara, cra,
                  wov, cwov, cl, accf, cacc, acc, accrd, ub, uba});
   endfunction

   // Per-cycle model: position in the job follows from the tile period 4*SIZE+1.
   always begin
      @(posedge clk); #2;
      cyc++;
      if (rst) begin active = 0; pw = 0; pc = 0; end
      {e_busy, e_done, e_wre, e_are, e_cre, e_cal, e_accf, e_cacc, e_accrd, e_ub} = '0;
      e_wra = '0; e_ara = '0; e_cra = '0; e_acc = '0; e_uba = '0;
      e_wmw = !active && mem_write;
      e_amw = e_wmw;
      e_cmw = e_wmw && comp_out_valid;
      r = cyc - jstart;
      if (active) begin
         e_busy = 1;
         if (r < jn*P) begin
            tl = r / P; o = r % P;
            if (o < SIZE) begin
               e_wre = 1; e_wra = 7'(tl*SIZE + o);
               if (o < CW) begin e_cre = 1; e_cra = 6'(tl*CW + o); end
            end else begin
               kk = o - SIZE;
               e_cal = 1; e_accf = (tl == 0);
               if (kk < SIZE) begin e_are = 1; e_ara = 7'(tl*SIZE + kk); end
               e_cacc = (kk >= CW+2) && (kk <= CW+SIZE+1);
               for (int j = 0; j < SIZE; j++)
                  e_acc[j] = (kk >= SIZE+2+j) && (kk <= 2*SIZE+1+j);
            end
         end else if (r < jn*P + SIZE + 1) begin
            kk = r - jn*P;
            e_accrd = 1;
            if (kk >= 1) begin e_ub = 1; e_uba = 3'(kk - 1); end
         end else begin
            e_done = 1;
         end
      end
      e_wov = pw; e_cwov = pc;
      v_exp = pack(e_busy, e_done, e_wmw, e_amw, e_cmw, e_wre, e_are, e_cre, e_wra, e_ara, e_cra,
                   e_wov, e_cwov, e_cal, e_accf, e_cacc, e_acc, e_accrd, e_ub, e_uba);
      v_act = pack(busy, done, weight_mem_wr_en, act_mem_wr_en, comp_mem_wr_en, weight_rd_en,
                   act_rd_en, comp_rd_en, weight_rd_addr, act_rd_addr, comp_rd_addr,
                   weight_out_valid, cweight_out_valid, cal, acc_first, cacc_wr_en, acc_wr_en,
                   acc_rd_en, ub_wr_en, ub_wr_addr);
      n_cmp++;
      if (v_act !== v_exp) begin
         n_bad++;
         $display("FAIL cycle_outputs cyc=%0d rel=%0d got=%h want=%h", cyc, r, v_act, v_exp);
      end
      if (active && r >= 0 && r < 128) begin
         snap_wra[r] = weight_rd_addr; snap_cra[r] = comp_rd_addr;
         snap_acc[r] = acc_wr_en; snap_ub[r] = ub_wr_addr; snap_accf[r] = acc_first;
      end
      if (done) begin done_count++; last_done_rel = r; end
      pw = e_wre; pc = e_cre;
      if (!rst) begin
         if (active) begin
            if (abort) begin active = 0; pw = 0; pc = 0; end
            else if (e_done) active = 0;
         end else if (start && !mem_write) begin
            active = 1; jstart = cyc + 1;
            jn = (num_tiles == 0) ? 1 : (int'(num_tiles) > MAXT ? MAXT : int'(num_tiles));
            for (int i = 0; i < 128; i++) begin
               snap_wra[i] = 'x; snap_cra[i] = 'x; snap_acc[i] = 'x; snap_ub[i] = 'x; snap_accf[i] = 'x;
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk); #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d want=%0d", name, act, exp);
      end
   endtask

   task automatic start_job(input int n);
      tick; start = 1; num_tiles = 5'(n);
      tick; start = 0;
   endtask

   task automatic wait_done(input int dc0);
      for (int i = 0; i < 800 && done_count == dc0; i++) tick;
      if (done_count == dc0) check("done_timeout", 0, 1);
   endtask

   int dc;

   initial begin
      repeat (3) tick;
      check("reset_busy", int'(busy), 0);
      rst = 0;
      tick;

      // single tile
      dc = done_count; start_job(1); wait_done(dc);
      check("n1_done_cycle", last_done_rel, 42);
      for (int i = 0; i < SIZE; i++) check("n1_wra", int'(snap_wra[i]), i);
      check("n1_acc_k10", int'(snap_acc[18]), 8'h01);
      check("n1_acc_k17", int'(snap_acc[25]), 8'hFF);
      check("n1_acc_k24", int'(snap_acc[32]), 8'h80);
      check("n1_ub_first", int'(snap_ub[34]), 0);
      check("n1_ub_last", int'(snap_ub[41]), 7);

      // two tiles with cross-tile accumulation
      dc = done_count; start_job(2); wait_done(dc);
      check("n2_done_cycle", last_done_rel, 75);
      check("n2_wra_t1_first", int'(snap_wra[33]), 8);
      check("n2_wra_t1_last", int'(snap_wra[40]), 15);
      for (int i = 0; i < CW; i++) check("n2_cra_t1", int'(snap_cra[33+i]), 3+i);
      check("n2_accf_t0", int'(snap_accf[8]), 1);
      check("n2_accf_t1", int'(snap_accf[41]), 0);

      // tile count edge values
      dc = done_count; start_job(0); wait_done(dc);
      check("n0_done_cycle", last_done_rel, 42);
      dc = done_count; start_job(20); wait_done(dc);
      check("n20_done_cycle", last_done_rel, 16*33+9);

      // host writes in IDLE, start masked by mem_write
      for (int i = 0; i < 6; i++) begin
         tick; mem_write = i[0]; comp_out_valid = i[1];
         #1 check("idle_wmw", int'(weight_mem_wr_en), int'(i[0]));
         check("idle_cmw", int'(comp_mem_wr_en), int'(i[0] & i[1]));
      end
      tick; mem_write = 1; start = 1; num_tiles = 5'd1;
      repeat (3) tick;
      mem_write = 0; start = 0; comp_out_valid = 0;
      tick; check("start_masked_busy", int'(busy), 0);

      // writes during busy are suppressed
      dc = done_count; start_job(1);
      repeat (5) tick;
      mem_write = 1; comp_out_valid = 1;
      repeat (20) tick;
      mem_write = 0; comp_out_valid = 0;
      wait_done(dc);
      check("memwr_busy_done", last_done_rel, 42);

      // abort at CAL k=5 of tile 1
      dc = done_count; start_job(2);
      repeat (46) tick;
      abort = 1; tick; abort = 0;
      check("abort_busy", int'(busy), 0);
      repeat (60) tick;
      check("abort_no_done", done_count, dc);
      dc = done_count; start_job(1); wait_done(dc);
      check("after_abort_done", last_done_rel, 42);
      check("after_abort_wra0", int'(snap_wra[0]), 0);

      // asynchronous reset mid-OUT
      dc = done_count; start_job(1);
      repeat (36) tick;
      rst = 1; #2;
      check("rst_async_busy", int'(busy), 0);
      check("rst_async_accrd", int'(acc_rd_en), 0);
      tick; rst = 0;
      tick;

      // start while busy is ignored
      dc = done_count; start_job(1);
      repeat (10) tick;
      start = 1; num_tiles = 5'd3; tick; start = 0;
      wait_done(dc);
      check("start_busy_done", last_done_rel, 42);
      repeat (3) tick;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

endmodule
